// File: rtl/accel_sample_reader.sv
// SPI (mode 3) master for a 3-axis accelerometer: one power-control write after reset,
// then a periodic 16-bit X-axis read presented on data_x with a one-cycle data_update.
module accel_sample_reader #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned SAMPLE_PERIOD = 200,
  parameter logic [5:0]  REG_ADDR      = 6'h32,
  parameter logic [5:0]  INIT_ADDR     = 6'h2D,
  parameter logic [7:0]  INIT_DATA     = 8'h08
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  output logic [15:0] data_x,
  output logic        data_update,
  output logic        busy
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TMR_W = $clog2(SAMPLE_PERIOD);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

  // Half-phase index: 0 = setup, 1..2N alternate sclk low/high, 2N+1 = hold.
  localparam logic [5:0] HALF_LAST_INIT = 6'd33;
  localparam logic [5:0] HALF_LAST_READ = 6'd49;

  localparam logic [23:0] INIT_FRAME = {2'b00, INIT_ADDR, INIT_DATA, 8'h00};
  localparam logic [23:0] READ_FRAME = {2'b11, REG_ADDR, 16'h0000};

  typedef enum logic [1:0] {
    S_INIT,
    S_INIT_XFER,
    S_IDLE,
    S_READ_XFER
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_sclk;
  logic             r_cs_n;
  logic             r_mosi;
  logic [15:0]      r_data;
  logic             r_update;
  logic             r_busy;
  logic [TMR_W-1:0] r_timer;
  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_half;
  logic [23:0]      r_tx;
  logic [15:0]      r_rx;

  logic       w_in_xfer;
  logic [5:0] w_half_last;
  logic [5:0] w_h_nxt;
  logic       w_xfer_end;
  logic       w_tick;
  logic       w_low_ph;
  logic       w_rise_ph;
  logic       w_start_init;
  logic       w_start_read;

  assign spi_sclk    = r_sclk;
  assign spi_cs_n    = r_cs_n;
  assign spi_mosi    = r_mosi;
  assign data_x      = r_data;
  assign data_update = r_update;
  assign busy        = r_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_init = 1'b0;
    w_start_read = 1'b0;
    w_in_xfer    = (r_state == S_INIT_XFER) || (r_state == S_READ_XFER);
    w_half_last  = (r_state == S_READ_XFER) ? HALF_LAST_READ : HALF_LAST_INIT;
    w_xfer_end   = w_in_xfer && (r_div == DIV_LAST) && (r_half == w_half_last);
    w_tick       = (r_timer == TMR_LAST);
    w_h_nxt      = r_half + 6'd1;
    w_low_ph     = w_h_nxt[0] && (w_h_nxt < w_half_last);
    w_rise_ph    = !w_h_nxt[0] && (w_h_nxt >= 6'd2);

    case (r_state)
      S_INIT: begin
        w_state_nxt  = S_INIT_XFER;
        w_start_init = 1'b1;
      end
      S_INIT_XFER: begin
        if (w_xfer_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (w_tick && enable) begin
          w_state_nxt  = S_READ_XFER;
          w_start_read = 1'b1;
        end
      end
      S_READ_XFER: begin
        if (w_xfer_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sclk   <= 1'b1;
      r_cs_n   <= 1'b1;
      r_mosi   <= 1'b0;
      r_data   <= '0;
      r_update <= 1'b0;
      r_busy   <= 1'b0;
      r_timer  <= '0;
      r_div    <= '0;
      r_half   <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
    end else begin
      r_update <= 1'b0;

      // Timer only runs once configured; it is held at zero through the init write.
      if (r_state == S_IDLE || r_state == S_READ_XFER) begin
        r_timer <= w_tick ? '0 : r_timer + 1'b1;
      end else begin
        r_timer <= '0;
      end

      if (w_start_init || w_start_read) begin
        r_cs_n <= 1'b0;
        r_busy <= 1'b1;
        r_sclk <= 1'b1;
        r_mosi <= 1'b0;
        r_div  <= '0;
        r_half <= '0;
        r_tx   <= w_start_init ? INIT_FRAME : READ_FRAME;
      end else if (w_xfer_end) begin
        r_cs_n <= 1'b1;
        r_busy <= 1'b0;
        r_sclk <= 1'b1;
        r_mosi <= 1'b0;
        if (r_state == S_READ_XFER) begin
          // First data byte received is the low byte, second the high byte.
          r_data   <= {r_rx[7:0], r_rx[15:8]};
          r_update <= 1'b1;
        end
      end else if (w_in_xfer) begin
        if (r_div == DIV_LAST) begin
          r_div  <= '0;
          r_half <= w_h_nxt;
          if (w_low_ph) begin
            r_sclk <= 1'b0;
            r_mosi <= r_tx[23];
            r_tx   <= {r_tx[22:0], 1'b0};
          end else begin
            r_sclk <= 1'b1;
            if (w_rise_ph) begin
              r_rx <= {r_rx[14:0], spi_miso};
            end
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_accel_sample_reader.sv
// Bench for accel_sample_reader: SPI slave model, read-data scoreboard and
// frame-level reference checks against the accelerometer protocol.
module tb_accel_sample_reader;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned SP      = 200;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        spi_miso = 1'b0;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic [15:0] data_x;
  logic        data_update;
  logic        busy;

  accel_sample_reader #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SP),
    .REG_ADDR     (6'h32),
    .INIT_ADDR    (6'h2D),
    .INIT_DATA    (8'h08)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .spi_miso   (spi_miso),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .data_x     (data_x),
    .data_update(data_update),
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned cyc      = 0;
  logic        rst_seen = 1'b0;

  // Stimulus pushes: miso stream {cmd-phase filler, low, high} and the expected data_x.
  logic [23:0] resp_q[$];
  logic [15:0] exp_q[$];
  int unsigned rd_fall_q[$];

  logic        prev_cs     = 1'b1;
  logic        prev_sclk   = 1'b1;
  bit          in_xfer     = 1'b0;
  bit          expect_init = 1'b0;
  int unsigned slv_nb      = 0;
  int unsigned slv_len     = 0;
  logic [23:0] slv_word    = '0;
  logic [23:0] cur_resp    = '0;
  int unsigned fall_cyc    = 0;
  int unsigned init_rise   = 0;
  int unsigned init_cnt    = 0;
  int unsigned n_falls     = 0;
  int unsigned n_strobes   = 0;
  logic [15:0] last_data   = '0;
  logic [15:0] exp_e;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic end_xfer();
    chk("xfer_bit_count_valid", (slv_nb == 16 || slv_nb == 24), 1);
    chk("cs_low_cycles", slv_len, CLK_DIV * (2 + 2 * slv_nb));
    if (expect_init) begin
      chk("first_xfer_is_init", slv_nb, 16);
      expect_init = 1'b0;
    end
    if (slv_nb == 16) begin
      chk("init_word", slv_word[15:0], 16'h2D08);
      init_rise = cyc;
      init_cnt++;
    end else if (slv_nb == 24) begin
      chk("read_cmd", slv_word[23:16], 8'hF2);
      chk("read_mosi_zero", slv_word[15:0], 16'h0000);
      chk("read_on_timer_wrap", (fall_cyc - init_rise) % SP, 0);
      rd_fall_q.push_back(fall_cyc);
      if (resp_q.size() > 0) void'(resp_q.pop_front());
    end
    in_xfer = 1'b0;
  endtask

  // Slave model plus monitor, sampling on the inactive clock edge.
  always @(negedge clock) begin
    if (rst_seen) begin
      chk("rst_cs_n", spi_cs_n, 1);
      chk("rst_sclk", spi_sclk, 1);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_data_x", data_x, 0);
      chk("rst_update", data_update, 0);
      chk("rst_busy", busy, 0);
      last_data   = '0;
      in_xfer     = 1'b0;
      expect_init = 1'b1;
      spi_miso    = 1'b0;
    end else begin
      chk("busy_vs_cs", busy, !spi_cs_n);
      if (!spi_cs_n && prev_cs) begin
        in_xfer  = 1'b1;
        slv_nb   = 0;
        slv_len  = 0;
        slv_word = '0;
        fall_cyc = cyc;
        cur_resp = (resp_q.size() > 0) ? resp_q[0] : 24'h0;
        n_falls++;
      end
      if (!spi_cs_n && in_xfer) begin
        slv_len++;
        if (prev_sclk && !spi_sclk && slv_nb < 24) spi_miso = cur_resp[23 - slv_nb];
        if (!prev_sclk && spi_sclk) begin
          slv_word = {slv_word[22:0], spi_mosi};
          slv_nb++;
        end
      end
      if (spi_cs_n && !prev_cs && in_xfer) end_xfer();

      if (data_update) begin
        n_strobes++;
        chk("strobe_on_cs_rise", {prev_cs, spi_cs_n}, 2'b01);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_strobe: data_x %0h with no read outstanding", data_x);
        end else begin
          exp_e = exp_q.pop_front();
          chk("data_x", data_x, exp_e);
          last_data = exp_e;
        end
      end else begin
        chk("data_x_hold", data_x, last_data);
      end
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  task automatic push_read(input logic [7:0] lo, input logic [7:0] hi);
    resp_q.push_back({8'($urandom), lo, hi});
    exp_q.push_back({hi, lo});
  endtask

  task automatic do_read(input logic [7:0] lo, input logic [7:0] hi, input bit toggle);
    int unsigned s0 = n_strobes;
    bit got = 1'b0;
    bit dropped = 1'b0;
    int unsigned t = 0;
    push_read(lo, hi);
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clock);
      #1;
      if (toggle && busy && !dropped) begin
        enable  = 1'b0;
        dropped = 1'b1;
        t       = i;
      end
      if (dropped && !enable && i == int'(t) + 20) enable = 1'b1;
      if (n_strobes != s0) got = 1'b1;
    end
    chk("read_completed", got, 1);
  endtask

  task automatic wait_init(input int unsigned c0);
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      #1;
      if (init_cnt != c0) got = 1'b1;
    end
    chk("init_completed", got, 1);
  endtask

  initial begin
    int unsigned f0, s0, t_en, d, n;
    bit found;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (5) @(negedge clock);
    #1 reset = 1'b0;

    // Init write happens with enable low; no reads may follow while disabled.
    wait_init(0);
    repeat (250) @(negedge clock);
    #1 chk("no_read_while_disabled", n_falls, 1);

    enable = 1'b1;
    do_read(8'h34, 8'h12, 1'b0);
    do_read(8'hF0, 8'hFF, 1'b0);
    do_read(8'h00, 8'h80, 1'b0);
    for (int k = 0; k < 6; k++) do_read(8'($urandom), 8'($urandom), 1'b0);

    // Disabled for three periods: no activity, then resume on the next wrap.
    enable = 1'b0;
    f0 = n_falls;
    s0 = n_strobes;
    repeat (3 * SP) @(negedge clock);
    #1;
    chk("disabled_no_cs", n_falls, f0);
    chk("disabled_no_strobe", n_strobes, s0);
    t_en   = cyc;
    enable = 1'b1;
    do_read(8'($urandom), 8'($urandom), 1'b0);
    d = rd_fall_q[$] - t_en;
    chk("resume_waits_for_wrap", (d >= 1 && d <= SP), 1);

    // Five consecutive periods, with enable pulsed low inside one read.
    for (int k = 0; k < 5; k++) do_read(8'($urandom), 8'($urandom), k == 2);
    n = rd_fall_q.size();
    for (int k = 1; k <= 5; k++)
      chk("read_spacing", rd_fall_q[n - k] - rd_fall_q[n - k - 1], SP);

    // Reset in the middle of a read aborts it and restarts configuration.
    push_read(8'($urandom), 8'($urandom));
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clock);
      #1;
      if (!spi_cs_n && in_xfer && slv_nb == 10) found = 1'b1;
    end
    chk("reached_tenth_rise", found, 1);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    resp_q.delete();
    exp_q.delete();
    reset = 1'b0;
    wait_init(init_cnt);
    do_read(8'($urandom), 8'($urandom), 1'b0);
    do_read(8'($urandom), 8'($urandom), 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("responses_consumed", resp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    n_fails++;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $fatal(1, "watchdog expired");
  end

endmodule
